fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer side of the program-counter interface.
- Takes a start/redirect address from the PC/branch logic and issues sequential word fetches to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents instruction+address pairs to decode with valid/ready.
- Decouples variable memory latency from the execute loop and discards stale fetches after a redirect.

Parameters:
- ADDR_WIDTH, 16, fetch address width (word addressed).
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  load new fetch address (jump/branch/PC store) this cycle.
- redirect_pc  input  ADDR_WIDTH  target address for redirect.
- mem_req_valid  output  1  fetch request pending.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  ADDR_WIDTH  word address of request.
- mem_rsp_valid  input  1  in-order read data returned this cycle (no backpressure).
- mem_rsp_data  input  INSTR_WIDTH  returned instruction word.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode consumes head this cycle.
- instr_data  output  INSTR_WIDTH  head instruction.
- instr_pc  output  ADDR_WIDTH  address of head instruction.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - fetch_pc=RESET_PC, deliver_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_count=0.
  - mem_req_valid=0, instr_valid=0, mem_req_addr=RESET_PC.
- Request issue:
  - mem_req_valid=1 iff (occupancy+outstanding) < DEPTH and no redirect this cycle.
  - mem_req_addr=fetch_pc.
  - On accept (valid&ready): fetch_pc+=1 mod 2^ADDR_WIDTH (0xFFFF wraps to 0x0000); outstanding+=1.
- Response:
  - Each mem_rsp_valid decrements outstanding, earliest next cycle after accept.
  - If drop_count>0: data discarded, drop_count-=1.
  - Else: pushed to FIFO tail. The credit rule guarantees a push never hits a full FIFO.
- Delivery:
  - instr_valid=FIFO non-empty; instr_data=head; instr_pc=deliver_pc.
  - On instr_valid&instr_ready: pop, deliver_pc+=1 (wraps).
  - A response pushed in cycle N is visible at instr_valid in cycle N+1 (1-cycle latency).
  - Simultaneous push and pop are allowed at any occupancy, including full.
- Redirect (highest priority, single cycle):
  - FIFO flushed; a pop in the same cycle is ignored. Decode must treat the head as killed.
  - fetch_pc<=redirect_pc, deliver_pc<=redirect_pc.
  - drop_count<=outstanding + (request accepted this cycle) − (response arrived this cycle), after that response's own drop handling. All in-flight fetches are discarded.
  - mem_req_valid forced 0 in the redirect cycle; fetching resumes next cycle at redirect_pc.
  - Back-to-back redirects: the last one wins; drop_count accumulates correctly.
- Invariants:
  - occupancy+outstanding ≤ DEPTH.
  - drop_count ≤ outstanding.
  - A response with outstanding==0 is a protocol error; it is ignored under assertion.
- Mid-operation reset: all counters and the FIFO clear immediately. Memory responses after reset deassertion are the memory's responsibility; the block treats them as illegal.

Decomposition:
- fetch_pkg: ADDR_WIDTH/INSTR_WIDTH defaults, RESET_PC, typedef fetch_addr_t, typedef instr_t.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, count, empty, full; async active-low reset. fetch_queue holds the counters, the fetch/deliver PCs, and the redirect logic.

Test Plan:
- Reset release, memory 1-cycle latency, instr_ready=1 → requests at 0x0000,0x0001,…; instr_pc matches; first instr_valid 2 cycles after first accept.
- instr_ready=0, memory always ready → exactly 4 requests issued, FIFO full, mem_req_valid=0 until one pop, then exactly one new request.
- Memory latency 3, 3 requests outstanding, redirect_pc=0x0100 → 3 responses dropped, next instr_pc=0x0100 with data from address 0x0100.
- redirect_pc=0xFFFE, free-running → addresses 0xFFFE,0xFFFF,0x0000,0x0001; instr_pc wraps identically.
- Redirect coinciding with an accepted request and an arriving response → drop_count correct; no stale instruction is ever delivered.
- reset_n pulsed low mid-stream with a full FIFO → instr_valid and mem_req_valid drop asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared defaults and types for the instruction fetch queue.
//   ADDR_WIDTH_DEF  : fetch address width (word addressed)
//   INSTR_WIDTH_DEF : instruction word width
//   DEPTH_DEF       : fetch FIFO entries (power of two, >= 2)
//   RESET_PC_DEF    : first fetch address after reset
//   fetch_addr_t    : word address type
//   instr_t         : instruction word type
//   cnt_width()     : width of a counter that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 16;
    localparam int INSTR_WIDTH_DEF = 32;
    localparam int DEPTH_DEF       = 4;

    typedef logic [ADDR_WIDTH_DEF-1:0]  fetch_addr_t;
    typedef logic [INSTR_WIDTH_DEF-1:0] instr_t;

    localparam fetch_addr_t RESET_PC_DEF = 16'h0000;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding returned instruction words.
//   clock, reset_n : clock and asynchronous active-low reset
//   push/push_data : write an entry at the tail
//   pop            : remove the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop in the same cycle
//   head_data      : current head entry (only meaningful when !empty)
//   count          : number of stored entries, 0..DEPTH
//   empty          : no entries stored
// Push and pop in the same cycle are allowed at any occupancy, including full.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle; the slot being freed is the one the write pointer lands on.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Issues sequential word fetches to instruction memory starting at RESET_PC or
// the latest redirect target, buffers in-order responses and hands
// instruction/address pairs to decode.
//   clock, reset_n        : clock and asynchronous active-low reset
//   redirect_valid/_pc    : load a new fetch address; flushes everything in flight
//   mem_req_valid/_ready  : fetch request channel, mem_req_addr is the word address
//   mem_rsp_valid/_data   : in-order read data, no backpressure
//   instr_valid/_ready    : decode channel, instr_data/instr_pc describe the head
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. valid never depends on ready. mem_req_valid and mem_req_addr are
// combinational from internal state and redirect_valid; instr_valid, instr_data
// and instr_pc are purely registered state.
//
// Credit scheme: a request is only issued while FIFO occupancy plus requests in
// flight is below DEPTH, so every response has a FIFO slot reserved for it.
// After a redirect, drop_count counts the stale responses still to come back.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH             = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH            = INSTR_WIDTH_DEF,
    parameter int DEPTH                  = DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int CW = cnt_width(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] deliver_pc_q;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         outstanding_d;
    logic [CW-1:0]         drop_count_q;
    logic [CW-1:0]         drop_count_d;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [CW:0]           credit_used;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  rsp_drop;
    logic                  fifo_push;
    logic                  fifo_pop;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
    // reset_n gates the request so nothing is offered while reset is held.
    assign mem_req_valid = reset_n && !redirect_valid &&
                           (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // ------------------------------------------------------------------
    // Response side: a response with nothing outstanding is illegal and
    // ignored so the counters cannot underflow.
    // ------------------------------------------------------------------
    assign rsp_fire  = mem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop  = rsp_fire && (drop_count_q != '0);
    // A response landing in a redirect cycle belongs to the old stream.
    assign fifo_push = rsp_fire && !rsp_drop && !redirect_valid;

    // ------------------------------------------------------------------
    // Delivery side
    // ------------------------------------------------------------------
    assign instr_valid = !fifo_empty;
    assign instr_pc    = deliver_pc_q;
    assign fifo_pop    = instr_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (mem_rsp_data),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (instr_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Counters. On a redirect every request still in flight after this
    // cycle's accept/response becomes stale, so drop_count takes the
    // updated outstanding value; a response already dropped this cycle is
    // naturally excluded because it has left outstanding.
    // ------------------------------------------------------------------
    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_count_d  = drop_count_q - CW'(rsp_drop);
        if (redirect_valid) begin
            drop_count_d = outstanding_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            if (redirect_valid) begin
                fetch_pc_q   <= redirect_pc;
                deliver_pc_q <= redirect_pc;
            end else begin
                if (req_fire) fetch_pc_q   <= fetch_pc_q + ADDR_WIDTH'(1);
                if (fifo_pop) deliver_pc_q <= deliver_pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol and credit invariants
    // ------------------------------------------------------------------
    a_rsp_has_request: assert property (@(posedge clock) disable iff (!reset_n)
        mem_rsp_valid |-> (outstanding_q != '0));
    a_credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
        credit_used <= (CW+1)'(DEPTH));
    a_drop_bound: assert property (@(posedge clock) disable iff (!reset_n)
        drop_count_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Bench for fetch_queue: a memory model with configurable latency, a
// queue-based reference model of the delivered instruction stream, a cycle
// table for the FIFO-full case, hand-written redirect/wrap/reset sequences and
// a randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam fetch_addr_t RESET_PC = RESET_PC_DEF;

    // ---------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    fetch_addr_t redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    fetch_addr_t mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    instr_t      mem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    instr_t      instr_data;
    fetch_addr_t instr_pc;

    always #5 clock = ~clock;

    fetch_queue dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    // ---------------------------------------------------------------
    // Reference model: memory in-flight list and expected FIFO contents
    // ---------------------------------------------------------------
    typedef struct {
        fetch_addr_t addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    fetch_addr_t exp_q[$];
    fetch_addr_t acc_log[$];
    fetch_addr_t del_log[$];
    fetch_addr_t fetch_model;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          rsp_now;
    bit          acc_now;
    bit          pop_now;
    bit          exp_rv;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic instr_t mem_word(input fetch_addr_t a);
        return {~a, a ^ 16'hC3A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Driver: called at negedge with this cycle's inputs already set.
    // Drives the memory response, then compares outputs against the model.
    // ---------------------------------------------------------------
    task automatic cycle_pre();
        rsp_now = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        mem_rsp_valid = rsp_now;
        mem_rsp_data  = rsp_now ? mem_word(pend_q[0].addr) : instr_t'($urandom);
        exp_rv = !redirect_valid && ((exp_q.size() + pend_q.size()) < DEPTH);
        #1;
        check("mem_req_valid", mem_req_valid, exp_rv);
        check("mem_req_addr", mem_req_addr, fetch_model);
        check("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("instr_pc", instr_pc, exp_q[0]);
            check("instr_data", instr_data, mem_word(exp_q[0]));
        end
        acc_now = exp_rv && mem_req_ready;
        pop_now = (exp_q.size() != 0) && instr_ready && !redirect_valid;
    endtask

    // Advances one clock and applies the same events to the model.
    task automatic cycle_post();
        pend_t e;
        @(posedge clock);
        if (pop_now) begin
            del_log.push_back(exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (rsp_now) begin
            e = pend_q.pop_front();
            if (!e.stale) exp_q.push_back(e.addr);
        end
        if (acc_now) begin
            acc_log.push_back(fetch_model);
            pend_q.push_back('{fetch_model, cyc + mem_lat, 1'b0});
            fetch_model = fetch_model + 16'd1;
        end
        if (redirect_valid) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            fetch_model = redirect_pc;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic step();
        cycle_pre();
        cycle_post();
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases
    // at the next negedge. Memory forgets everything in flight.
    task automatic apply_reset();
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        instr_ready    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, RESET_PC);
        exp_q.delete();
        pend_q.delete();
        fetch_model = RESET_PC;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check_log(input string name, input bit use_acc, input int idx, input fetch_addr_t exp);
        fetch_addr_t v;
        if (use_acc) v = (acc_log.size() > idx) ? acc_log[idx] : 16'hDEAD;
        else         v = (del_log.size() > idx) ? del_log[idx] : 16'hDEAD;
        check(name, v, exp);
    endtask

    // ---------------------------------------------------------------
    // Cycle table: instr_ready held low with memory always ready
    // ---------------------------------------------------------------
    typedef struct {
        logic        instr_ready;
        logic        exp_req_valid;
        fetch_addr_t exp_req_addr;
        logic        exp_instr_valid;
        fetch_addr_t exp_instr_pc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit found;

        vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0004, 1'b1, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0001};
        vecs[8] = '{1'b0, 1'b0, 16'h0005, 1'b1, 16'h0001};
        vecs[9] = '{1'b0, 1'b0, 16'h0005, 1'b1, 16'h0001};

        fetch_model = RESET_PC;
        @(negedge clock);

        // --- Test 1: free-running from reset, latency 1 ---
        apply_reset();
        mem_lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1;
        acc_log.delete(); del_log.delete();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 4; i++) begin
            check_log("t1_req_addr", 1'b1, i, fetch_addr_t'(i));
            check_log("t1_instr_pc", 1'b0, i, fetch_addr_t'(i));
        end

        // --- Test 2: decode stalled, FIFO fills, one pop frees one request ---
        apply_reset();
        mem_lat = 1; mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_ready = vecs[i].instr_ready;
            cycle_pre();
            check("tbl_req_valid", mem_req_valid, vecs[i].exp_req_valid);
            check("tbl_req_addr", mem_req_addr, vecs[i].exp_req_addr);
            check("tbl_instr_valid", instr_valid, vecs[i].exp_instr_valid);
            if (vecs[i].exp_instr_valid)
                check("tbl_instr_pc", instr_pc, vecs[i].exp_instr_pc);
            cycle_post();
        end

        // --- Test 3: latency 3, three in flight, redirect to 0x0100 ---
        apply_reset();
        mem_lat = 3; mem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle_pre();
            if (instr_valid && !found) begin
                found = 1'b1;
                check("t3_first_pc", instr_pc, 16'h0100);
                check("t3_first_data", instr_data, mem_word(16'h0100));
            end
            cycle_post();
        end
        check("t3_delivered_in_time", found, 1'b1);

        // --- Test 4: address wrap at the top of the address space ---
        mem_lat = 1;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        acc_log.delete(); del_log.delete();
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_log("t4_req0", 1'b1, 0, 16'hFFFE);
        check_log("t4_req1", 1'b1, 1, 16'hFFFF);
        check_log("t4_req2", 1'b1, 2, 16'h0000);
        check_log("t4_req3", 1'b1, 3, 16'h0001);
        check_log("t4_pc0", 1'b0, 0, 16'hFFFE);
        check_log("t4_pc1", 1'b0, 1, 16'hFFFF);
        check_log("t4_pc2", 1'b0, 2, 16'h0000);
        check_log("t4_pc3", 1'b0, 3, 16'h0001);

        // --- Test 5: back-to-back redirects with traffic in flight ---
        mem_lat = 2; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect_pc = 16'h0300;
        step();
        redirect_valid = 1'b0;
        del_log.delete();
        for (int i = 0; i < 12; i++) step();
        check_log("t5_last_redirect_wins", 1'b0, 0, 16'h0300);

        // --- Test 6: reset mid-stream with a full FIFO ---
        mem_lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t6_full_before_reset", instr_valid, 1'b1);
        apply_reset();
        mem_lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1;
        acc_log.delete(); del_log.delete();
        for (int i = 0; i < 6; i++) step();
        check_log("t6_restart_req", 1'b1, 0, RESET_PC);
        check_log("t6_restart_pc", 1'b0, 0, RESET_PC);

        // --- Randomized run against the model ---
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = {14'h3FFF, 2'($urandom_range(0, 3))};
            else
                redirect_pc = fetch_addr_t'($urandom);
            step();
        end
        redirect_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
